// File: rtl/servio_arb_mux_pkg.sv
// servio_arb_mux_pkg: FSM state encodings and beat-count helpers
// shared by the servio arbitrating memory mux and its arbiter.
package servio_arb_mux_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_ACK   = 2'd3;

    function automatic int lg2(input int v);
        return (v <= 1) ? 0 : $clog2(v);
    endfunction

    function automatic int beats_of(input int dw);
        return 32 / dw;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/servio_arb_mux_if.sv
// servio_arb_mux_if: Wishbone slave ports (NPORTS x 32-bit) plus the
// shared Avalon-MM memory port. slave = mux side, master = environment.
interface servio_arb_mux_if #(
    parameter int NPORTS = 4,
    parameter int MEM_DW = 8,
    parameter int AW     = 10
);
    logic [NPORTS*32-1:0] wb_adr;
    logic [NPORTS-1:0]    wb_cyc;
    logic [NPORTS-1:0]    wb_we;
    logic [NPORTS*32-1:0] wb_dat;
    logic [NPORTS*4-1:0]  wb_sel;
    logic [31:0]          wb_rdt;
    logic [NPORTS-1:0]    wb_ack;

    logic [AW-1:0]        avm_address;
    logic                 avm_read;
    logic                 avm_write;
    logic [MEM_DW-1:0]    avm_writedata;
    logic [MEM_DW/8-1:0]  avm_byteenable;
    logic                 avm_waitrequest;
    logic [MEM_DW-1:0]    avm_readdata;
    logic                 avm_readdatavalid;

    modport slave (
        input  wb_adr, wb_cyc, wb_we, wb_dat, wb_sel,
        output wb_rdt, wb_ack,
        output avm_address, avm_read, avm_write,
        output avm_writedata, avm_byteenable,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid
    );

    modport master (
        output wb_adr, wb_cyc, wb_we, wb_dat, wb_sel,
        input  wb_rdt, wb_ack,
        input  avm_address, avm_read, avm_write,
        input  avm_writedata, avm_byteenable,
        output avm_waitrequest, avm_readdata, avm_readdatavalid
    );
endinterface

// File: rtl/servio_arb_mux_rr_arbiter.sv
// servio_rr_arbiter: combinational round-robin pick of the first
// requester after i_ptr (wrapping). Ports: i_req, i_ptr -> o_gnt, o_idx, o_any.
module servio_rr_arbiter
    import servio_arb_mux_pkg::*;
#(
    parameter int NPORTS = 4,
    parameter int PW     = idx_w(NPORTS)
) (
    input  logic [NPORTS-1:0] i_req,
    input  logic [PW-1:0]     i_ptr,
    output logic [NPORTS-1:0] o_gnt,
    output logic [PW-1:0]     o_idx,
    output logic              o_any
);
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int k = 1; k <= NPORTS; k++) begin
            if (!o_any && i_req[(int'(i_ptr) + k) % NPORTS]) begin
                o_any = 1'b1;
                o_idx = PW'((int'(i_ptr) + k) % NPORTS);
                o_gnt[(int'(i_ptr) + k) % NPORTS] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/servio_arb_mux.sv
// servio_arb_mux: round-robin mux of NPORTS Wishbone masters onto one
// Avalon-MM port; each 32-bit access is split into 32/MEM_DW beats.
// Ports: clk, reset (sync, active high), bus (servio_arb_mux_if.slave).
module servio_arb_mux
    import servio_arb_mux_pkg::*;
#(
    parameter int NPORTS     = 4,
    parameter int DATA_DEPTH = 1024,
    parameter int MEM_DW     = 8
) (
    input logic clk,
    input logic reset,
    servio_arb_mux_if.slave bus
);
    localparam int AW    = $clog2(DATA_DEPTH);
    localparam int BEATS = beats_of(MEM_DW);
    localparam int BW    = lg2(BEATS);
    localparam int OFS   = lg2(MEM_DW / 8);
    localparam int NB    = MEM_DW / 8;
    localparam int CW    = BW + 1;
    localparam int PW    = idx_w(NPORTS);

    logic [1:0]        r_state;
    logic [PW-1:0]     r_ptr;
    logic [PW-1:0]     r_gnt;
    logic [NPORTS-1:0] r_gnt_oh;
    logic [NPORTS-1:0] r_ack;
    logic [AW-1:0]     r_base;
    logic              r_we;
    logic [31:0]       r_dat;
    logic [3:0]        r_sel;
    logic [CW-1:0]     r_beat;
    logic [CW-1:0]     r_rcnt;
    logic [31:0]       r_rdata;

    logic [NPORTS-1:0] w_req;
    logic [NPORTS-1:0] w_gnt_oh;
    logic [PW-1:0]     w_gnt;
    logic              w_any;
    logic              w_issue;
    logic              w_acc;
    logic              w_last;
    logic              w_rv;
    logic [CW-1:0]     w_rcnt_nx;
    logic              w_done;

    // masking by ack keeps a held cyc from being re-granted in its ack cycle
    assign w_req = bus.wb_cyc & ~r_ack;

    servio_rr_arbiter #(
        .NPORTS(NPORTS),
        .PW    (PW)
    ) u_arb (
        .i_req(w_req),
        .i_ptr(r_ptr),
        .o_gnt(w_gnt_oh),
        .o_idx(w_gnt),
        .o_any(w_any)
    );

    assign w_issue = (r_state == ST_ISSUE);
    assign w_acc   = w_issue && !bus.avm_waitrequest;
    assign w_last  = (r_beat == CW'(BEATS - 1));

    // read beats may return while later beats are still being issued
    assign w_rv = bus.avm_readdatavalid
               && (r_rcnt != CW'(BEATS))
               && ((w_issue && !r_we) || r_state == ST_WAIT);
    assign w_rcnt_nx = r_rcnt + CW'(w_rv);
    assign w_done    = (w_rcnt_nx == CW'(BEATS));

    // low address bits select the beat within the 32-bit word
    assign bus.avm_address = w_issue
        ? ((r_base & ~AW'(BEATS - 1)) | AW'(r_beat)) : '0;
    assign bus.avm_read  = w_issue && !r_we;
    assign bus.avm_write = w_issue && r_we;
    assign bus.avm_writedata = (w_issue && r_we)
        ? r_dat[int'(r_beat)*MEM_DW +: MEM_DW] : '0;
    assign bus.avm_byteenable = (w_issue && r_we)
        ? r_sel[int'(r_beat)*NB +: NB] : '0;

    assign bus.wb_rdt = r_rdata;
    assign bus.wb_ack = r_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_ptr    <= PW'(NPORTS - 1);
            r_gnt    <= '0;
            r_gnt_oh <= '0;
            r_ack    <= '0;
            r_base   <= '0;
            r_we     <= 1'b0;
            r_dat    <= '0;
            r_sel    <= '0;
            r_beat   <= '0;
            r_rcnt   <= '0;
            r_rdata  <= '0;
        end else begin
            r_ack  <= '0;
            r_rcnt <= w_rcnt_nx;
            if (w_rv)
                r_rdata[int'(r_rcnt)*MEM_DW +: MEM_DW] <= bus.avm_readdata;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_gnt    <= w_gnt;
                        r_gnt_oh <= w_gnt_oh;
                        r_base   <= AW'(bus.wb_adr[int'(w_gnt)*32 +: 32] >> OFS);
                        r_we     <= bus.wb_we[w_gnt];
                        r_dat    <= bus.wb_dat[int'(w_gnt)*32 +: 32];
                        r_sel    <= bus.wb_sel[int'(w_gnt)*4 +: 4];
                        r_beat   <= '0;
                        r_rcnt   <= '0;
                        r_state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_acc) begin
                        if (!w_last) begin
                            r_beat <= r_beat + CW'(1);
                        end else if (r_we || w_done) begin
                            r_ack   <= r_gnt_oh;
                            r_state <= ST_ACK;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (w_done) begin
                        r_ack   <= r_gnt_oh;
                        r_state <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    r_ptr   <= r_gnt;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_servio_arb_mux.sv
// tb_servio_arb_mux: directed vectors and corner sequences for
// servio_arb_mux (8-bit and 16-bit memory instances).
module tb_servio_arb_mux;

    typedef struct {
        int          port;
        bit          we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] rdt;
        logic [9:0]  base;
        int          lat;
    } vec_t;

    typedef struct {
        int          due;
        logic [15:0] d;
    } rsp_t;

    typedef struct packed {
        logic [9:0] a;
        logic [7:0] d;
        logic       be;
    } wlog_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    servio_arb_mux_if #(.NPORTS(4), .MEM_DW(8),  .AW(10)) ia ();
    servio_arb_mux_if #(.NPORTS(2), .MEM_DW(16), .AW(10)) ib ();

    servio_arb_mux #(.NPORTS(4), .DATA_DEPTH(1024), .MEM_DW(8)) u_dut_a (
        .clk  (clk),
        .reset(reset),
        .bus  (ia)
    );

    servio_arb_mux #(.NPORTS(2), .DATA_DEPTH(1024), .MEM_DW(16)) u_dut_b (
        .clk  (clk),
        .reset(reset),
        .bus  (ib)
    );

    int total = 0;
    int bad = 0;
    int cyc_cnt = 0;
    int lat_a = 1;
    int st_left = 0;
    logic [9:0] st_target = '0;

    rsp_t       rq_a[$];
    rsp_t       rq_b[$];
    logic [9:0] rd_log_a[$];
    logic [9:0] rd_log_b[$];
    wlog_t      wr_log_a[$];

    vec_t vt[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc_cnt++;
    end

    // memory model A: 8-bit entries, data = low address byte
    initial begin
        ia.avm_waitrequest = 1'b0;
        ia.avm_readdata = '0;
        ia.avm_readdatavalid = 1'b0;
        forever begin
            @(negedge clk);
            if (rq_a.size() > 0 && rq_a[0].due <= cyc_cnt) begin
                ia.avm_readdatavalid = 1'b1;
                ia.avm_readdata = rq_a[0].d[7:0];
                rq_a.delete(0);
            end else begin
                ia.avm_readdatavalid = 1'b0;
                ia.avm_readdata = '0;
            end
            ia.avm_waitrequest = 1'b0;
            if ((ia.avm_read || ia.avm_write) && ia.avm_address == st_target
                && st_left > 0) begin
                ia.avm_waitrequest = 1'b1;
                st_left--;
            end
            if (ia.avm_read && !ia.avm_waitrequest) begin
                rq_a.push_back('{cyc_cnt + lat_a, {8'h00, ia.avm_address[7:0]}});
                rd_log_a.push_back(ia.avm_address);
            end
            if (ia.avm_write && !ia.avm_waitrequest)
                wr_log_a.push_back('{ia.avm_address, ia.avm_writedata, ia.avm_byteenable[0]});
        end
    end

    // memory model B: 16-bit entries, latency 4
    initial begin
        ib.avm_waitrequest = 1'b0;
        ib.avm_readdata = '0;
        ib.avm_readdatavalid = 1'b0;
        forever begin
            @(negedge clk);
            if (rq_b.size() > 0 && rq_b[0].due <= cyc_cnt) begin
                ib.avm_readdatavalid = 1'b1;
                ib.avm_readdata = rq_b[0].d;
                rq_b.delete(0);
            end else begin
                ib.avm_readdatavalid = 1'b0;
                ib.avm_readdata = '0;
            end
            if (ib.avm_read) begin
                rq_b.push_back('{cyc_cnt + 4,
                    {ib.avm_address[7:0] ^ 8'h5A, ib.avm_address[7:0]}});
                rd_log_b.push_back(ib.avm_address);
            end
        end
    end

    task automatic run_vec(input string nm, input vec_t v);
        int n;
        logic [9:0] ga;
        wlog_t e;
        wlog_t gw;
        @(posedge clk);
        @(negedge clk);
        rd_log_a.delete();
        wr_log_a.delete();
        ia.wb_adr[v.port*32 +: 32] = v.adr;
        ia.wb_dat[v.port*32 +: 32] = v.dat;
        ia.wb_sel[v.port*4 +: 4] = v.sel;
        ia.wb_we[v.port] = v.we;
        ia.wb_cyc[v.port] = 1'b1;
        n = 0;
        while (ia.wb_ack == 4'h0 && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({nm, "_lat"}, 64'(n), 64'(v.lat));
        chk({nm, "_ack"}, 64'(ia.wb_ack), 64'(4'b0001 << v.port));
        if (!v.we)
            chk({nm, "_rdt"}, 64'(ia.wb_rdt), 64'(v.rdt));
        ia.wb_cyc[v.port] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!v.we) begin
                ga = (k < rd_log_a.size()) ? rd_log_a[k] : '1;
                chk($sformatf("%s_radr%0d", nm, k), 64'(ga), 64'(v.base + 10'(k)));
            end else begin
                e.a = v.base + 10'(k);
                e.d = v.dat[k*8 +: 8];
                e.be = v.sel[k];
                gw = (k < wr_log_a.size()) ? wr_log_a[k] : '1;
                chk($sformatf("%s_wbeat%0d", nm, k), 64'(gw), 64'(e));
            end
        end
    endtask

    initial begin
        int n;
        int k;
        int acks;
        vec_t vw;

        vt[0] = '{0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'h1312_1110, 10'h010, 6};
        vt[1] = '{2, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 4'b0101, 32'h0, 10'h020, 5};
        vt[2] = '{3, 1'b0, 32'h0000_03FC, 32'h0, 4'h0, 32'hFFFE_FDFC, 10'h3FC, 6};
        vt[3] = '{1, 1'b0, 32'hFFFF_F406, 32'h0, 4'h0, 32'h0706_0504, 10'h004, 6};
        vt[4] = '{1, 1'b1, 32'h0000_1235, 32'h0123_4567, 4'b1111, 32'h0, 10'h234, 5};
        vt[5] = '{3, 1'b1, 32'h0000_0008, 32'hCAFE_F00D, 4'b1010, 32'h0, 10'h008, 5};

        ia.wb_adr = '0; ia.wb_cyc = '0; ia.wb_we = '0; ia.wb_dat = '0; ia.wb_sel = '0;
        ib.wb_adr = '0; ib.wb_cyc = '0; ib.wb_we = '0; ib.wb_dat = '0; ib.wb_sel = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", 64'(ia.wb_ack), 64'(0));
        chk("rst_rdt", 64'(ia.wb_rdt), 64'(0));
        chk("rst_rd_wr", 64'({ia.avm_read, ia.avm_write}), 64'(0));
        chk("rst_addr", 64'(ia.avm_address), 64'(0));
        chk("rst_wdata_be", 64'({ia.avm_writedata, ia.avm_byteenable}), 64'(0));
        chk("rst_ack_b", 64'(ib.wb_ack), 64'(0));
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 6; i++)
            run_vec($sformatf("vec%0d", i), vt[i]);

        // 16-bit memory: two beats, read latency 4
        @(posedge clk);
        @(negedge clk);
        rd_log_b.delete();
        ib.wb_adr[31:0] = 32'h0000_0040;
        ib.wb_cyc = 2'b01;
        n = 0;
        while (ib.wb_ack == 2'b00 && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("dw16_lat", 64'(n), 64'(7));
        chk("dw16_ack", 64'(ib.wb_ack), 64'(2'b01));
        chk("dw16_rdt", 64'(ib.wb_rdt), 64'(32'h7B21_7A20));
        ib.wb_cyc = 2'b00;
        chk("dw16_nbeats", 64'(rd_log_b.size()), 64'(2));
        chk("dw16_a0", 64'(rd_log_b.size() > 0 ? rd_log_b[0] : 10'h3FF), 64'(10'h020));
        chk("dw16_a1", 64'(rd_log_b.size() > 1 ? rd_log_b[1] : 10'h3FF), 64'(10'h021));
        acks = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (ib.wb_ack != 2'b00) acks++;
        end
        chk("dw16_single_ack", 64'(acks), 64'(0));

        // waitrequest held for 3 cycles on beat 2 of a read
        st_target = 10'h012;
        st_left = 3;
        vw = '{0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'h1312_1110, 10'h010, 9};
        run_vec("wait", vw);
        chk("wait_stall", 64'(st_left), 64'(0));

        // continuous requests from all ports: fresh pointer, port 0 first
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int p = 0; p < 4; p++) begin
            ia.wb_adr[p*32 +: 32] = 32'h40 + 32'(p * 4);
            ia.wb_we[p] = 1'b0;
        end
        ia.wb_cyc = 4'hF;
        k = 0;
        n = 0;
        while (k < 8 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (ia.wb_ack != 4'h0) begin
                chk($sformatf("rr%0d", k), 64'(ia.wb_ack), 64'(4'b0001 << (k % 4)));
                k++;
            end
        end
        ia.wb_cyc = 4'h0;
        chk("rr_count", 64'(k), 64'(8));

        // reset in WAIT with beats outstanding, then stray returns
        lat_a = 4;
        @(posedge clk);
        @(negedge clk);
        ia.wb_adr[31:0] = 32'h0000_0010;
        ia.wb_we[0] = 1'b0;
        ia.wb_cyc[0] = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        ia.wb_cyc = 4'h0;
        @(posedge clk);
        #1;
        chk("abort_ack", 64'(ia.wb_ack), 64'(0));
        chk("abort_rdt", 64'(ia.wb_rdt), 64'(0));
        chk("abort_rd_wr", 64'({ia.avm_read, ia.avm_write}), 64'(0));
        chk("abort_addr", 64'(ia.avm_address), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        acks = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (ia.wb_ack != 4'h0) acks++;
        end
        chk("abort_no_ack", 64'(acks), 64'(0));
        chk("abort_stray_rdt", 64'(ia.wb_rdt), 64'(0));
        lat_a = 1;
        vw = '{1, 1'b0, 32'h0000_0030, 32'h0, 4'h0, 32'h3332_3130, 10'h030, 6};
        run_vec("after_rst", vw);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
